// File: rtl/clk_divider.sv
`timescale 1ns/1ps
// clk_divider
//   Integer clock divider. newClk has a period of DIV clk cycles: low for
//   floor(DIV/2) cycles, then high for ceil(DIV/2) cycles. newClk is driven
//   straight from a flop, so it is glitch-free and can be used either as a
//   clock or as a data signal downstream.
//
// Parameters
//   DIV    divide ratio, 2..65536
//   CW     counter width, derived from DIV (do not override)
//
// Ports
//   clk     in   system clock, all logic on its rising edge
//   reset   in   synchronous, active-high reset (priority over counting)
//   newClk  out  divided clock, registered
module clk_divider #(
    parameter int DIV = 4,
    parameter int CW  = (DIV > 2) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic reset,
    output logic newClk
);

    generate
        if (DIV < 2) begin : g_bad_div
            $fatal(1, "clk_divider: DIV must be at least 2");
        end
    endgenerate

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    // Declaration initialisers give defined power-up values, so the block
    // runs cleanly even when reset is never asserted.
    logic [CW-1:0] cnt_q    = '0;
    logic          newclk_q = 1'b0;
    logic [CW-1:0] cnt_d;
    logic          newclk_d;

    // newClk is decoded from the *next* count, so it lands in a flop on the
    // same edge as the counter and needs no extra pipeline stage.
    always_comb begin
        cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        newclk_d = (cnt_d >= HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            newclk_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            newclk_q <= newclk_d;
        end
    end

    assign newClk = newclk_q;

endmodule

// File: tb/tb_clk_divider.sv
`timescale 1ns/1ps
module tb_clk_divider;

    logic clk = 1'b0;
    logic rst2 = 1'b0, rst4 = 1'b0, rst5 = 1'b0, rst8 = 1'b0;
    logic nclk2, nclk4, nclk5, nclk8;

    int checks = 0;
    int fails  = 0;

    clk_divider #(.DIV(2)) u_div2 (.clk(clk), .reset(rst2), .newClk(nclk2));
    clk_divider #(.DIV(4)) u_div4 (.clk(clk), .reset(rst4), .newClk(nclk4));
    clk_divider #(.DIV(5)) u_div5 (.clk(clk), .reset(rst5), .newClk(nclk5));
    clk_divider #(.DIV(8)) u_div8 (.clk(clk), .reset(rst8), .newClk(nclk8));

    // clk period 4 ns, first rising edge at 2 ns
    initial forever #2 clk = ~clk;

    // Hand-computed newClk value after the n-th edge since reset/power-up,
    // indexed by (n-1) % DIV.
    int pat2[2] = '{1, 0};
    int pat4[4] = '{0, 1, 1, 0};
    int pat5[5] = '{0, 1, 1, 1, 0};
    int pat8[8] = '{0, 0, 0, 1, 1, 1, 1, 0};

    typedef struct packed {
        logic       e2;
        logic       e4;
        logic       e5;
        logic       e8;
        logic [2:0] c8;
    } exp_t;

    exp_t exp_q[$];
    int   edge_no = 0;
    int   n2 = 0, n4 = 0, n5 = 0, n8 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expectation generator: every rising edge, the reset value driven for
    // that edge determines the expected output, pushed into the scoreboard.
    initial forever begin
        exp_t e;
        @(posedge clk);
        edge_no++;
        if (rst2) begin n2 = 0; e.e2 = 1'b0; end
        else begin n2++; e.e2 = pat2[(n2-1) % 2] != 0; end
        if (rst4) begin n4 = 0; e.e4 = 1'b0; end
        else begin n4++; e.e4 = pat4[(n4-1) % 4] != 0; end
        if (rst5) begin n5 = 0; e.e5 = 1'b0; end
        else begin n5++; e.e5 = pat5[(n5-1) % 5] != 0; end
        if (rst8) begin n8 = 0; e.e8 = 1'b0; end
        else begin n8++; e.e8 = pat8[(n8-1) % 8] != 0; end
        e.c8 = 3'(n8 % 8);
        exp_q.push_back(e);
    end

    // Monitor: sample on the falling edge and compare against the scoreboard.
    int   rises5 = 0, rises8 = 0;
    logic prev5 = 1'b0, prev8 = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("div2_newClk", 32'(nclk2), 32'(e.e2));
            chk("div4_newClk", 32'(nclk4), 32'(e.e4));
            chk("div5_newClk", 32'(nclk5), 32'(e.e5));
            chk("div8_newClk", 32'(nclk8), 32'(e.e8));
            chk("div8_cnt", 32'(u_div8.cnt_q), 32'(e.c8));
        end
        if (edge_no <= 80) begin
            if (nclk5 && !prev5 && edge_no <= 50) rises5++;
            if (nclk8 && !prev8) rises8++;
        end
        prev5 = nclk5;
        prev8 = nclk8;
        if (edge_no == 50) chk("div5_periods_in_50", 32'(rises5), 32'd10);
        if (edge_no == 80) chk("div8_rises_in_80", 32'(rises8), 32'd10);
    end

    // Free-running DIV=4 timing: rises at 6, 22, 38 ... and 8 ns high phase.
    int  rises4 = 0;
    time last_rise4 = 0;
    initial forever begin
        @(posedge nclk4);
        if ($time < 500) begin
            chk("div4_rise_time_mod16", 32'($time % 16), 32'd6);
            rises4++;
            last_rise4 = $time;
        end
    end
    initial forever begin
        @(negedge nclk4);
        if ($time < 500) chk("div4_high_width", 32'($time - last_rise4), 32'd8);
    end

    initial begin
        bit found;
        #1;
        chk("powerup_div2", 32'(nclk2), 32'd0);
        chk("powerup_div4", 32'(nclk4), 32'd0);
        chk("powerup_div5", 32'(nclk5), 32'd0);
        chk("powerup_div8", 32'(nclk8), 32'd0);
        #499;
        chk("div4_rises_by_500ns", 32'(rises4), 32'd31);

        // Reset DIV=4 while it is high; bounded search for a high phase.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            #0;
            if (nclk4 === 1'b1) found = 1'b1;
        end
        chk("div4_found_high_phase", 32'(found), 32'd1);
        rst4 = 1'b1;
        rst5 = 1'b1;
        #1;
        chk("div4_reset_between_edges", 32'(nclk4), 32'd1);
        @(negedge clk);
        rst5 = 1'b0;
        rst2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        rst2 = 1'b0;

        // Mid-period reset on DIV=8 after a few cycles of counting.
        repeat (5) @(negedge clk);
        rst8 = 1'b1;
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        repeat (30) @(negedge clk);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Watchdog against a stalled clock or runaway test.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
